icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache that answers the instruction fetch stage's cache read port (address, read strobe, data, waitrequest) and refills lines from main memory over a pipelined read port. It sits between the fetch stage and the memory arbiter. Hits return data in the same cycle. Misses stall fetch via `cache_waitrequest` while a full line is fetched.

## Interface
- `ADDR_WIDTH`, default 32: byte address width on both ports.
- `DATA_WIDTH`, default 32: word width.
- `LINES`, default 64: number of lines, power of two.
- `LINE_WORDS`, default 4: words per line, power of two, ≥2.

Ports:
- `clock` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cache_addr` in ADDR_WIDTH: fetch byte address; bits [1:0] ignored.
- `cache_rd` in 1: fetch read request.
- `cache_data` out DATA_WIDTH: instruction word, valid when `cache_rd & ~cache_waitrequest`.
- `cache_waitrequest` out 1: fetch must hold/retry.
- `flush` in 1: invalidate all lines.
- `mem_addr` out ADDR_WIDTH: refill word address, word aligned.
- `mem_rd` out 1: refill read request.
- `mem_waitrequest` in 1: request not accepted this cycle.
- `mem_data` in DATA_WIDTH: refill data.
- `mem_rvalid` in 1: `mem_data` valid. Responses return in request order, at least 1 cycle after acceptance.

## Operation
- Address split: offset = bits [OB+1:2] with OB = log2(LINE_WORDS). Index = next log2(LINES) bits. Tag = remaining upper bits.
- Arrays: valid[LINES], tag[LINES], data[LINES×LINE_WORDS]. All are flop arrays read combinationally.
- States: IDLE, FILL.
- IDLE:
  - hit = `cache_rd & valid[idx] & tag match & ~flush`.
  - `cache_waitrequest = cache_rd & ~hit`.
  - `cache_data` = data[idx][offset]; it is don't-care when not hit.
  - On `cache_rd & ~hit & ~flush`: latch tag and index of `cache_addr`, clear req_cnt, resp_cnt and the kill flag, then go to FILL.
  - `flush` in IDLE: all valid bits clear at the next edge.
- FILL:
  - `cache_waitrequest = 1`.
  - `mem_rd = (req_cnt < LINE_WORDS)`.
  - `mem_addr = {latched tag, latched index, req_cnt[OB-1:0], 2'b00}`.
  - req_cnt increments when `mem_rd & ~mem_waitrequest`.
  - Each `mem_rvalid` writes data[idx][resp_cnt] and increments resp_cnt.
  - The edge that accepts the final response writes the tag, sets valid = ~kill, and returns to IDLE.
- Changes to `cache_addr` during FILL do not abort the refill. IDLE re-evaluates the current address after the refill.
- `flush` during FILL clears all valid bits immediately and sets kill, so the line being filled completes but stays invalid.
- `mem_rvalid` in IDLE is ignored. `cache_rd` low in IDLE: no miss, `cache_waitrequest` = 0.
- Reset mid-FILL: state returns to IDLE, all valid bits clear, counters clear. Responses still in flight are ignored.

## Timing
- Reset values: state IDLE, valid all 0, `mem_rd` 0, `mem_addr` 0, counters 0, `cache_waitrequest` = `cache_rd` (every line invalid).
- Hit latency: 0 cycles (combinational).
- Miss with zero-wait memory and 1-cycle response latency:
  - Miss detected in cycle 0.
  - `mem_rd` asserted in cycles 1..LINE_WORDS.
  - Responses arrive in cycles 2..LINE_WORDS+1.
  - The hit is returned in cycle LINE_WORDS+2.
  - `cache_waitrequest` stays high for LINE_WORDS+2 cycles (6 at default).
- `mem_addr` is held stable while `mem_rd & mem_waitrequest`.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` and `miss_count`, 32 bits each, reset to 0, wrapping on overflow.
  - `hit_count` increments on each IDLE hit cycle.
  - `miss_count` increments on each IDLE→FILL transition.
- Not defined: ports and counters absent. Behaviour is otherwise identical.

## Structure
- `icache_pkg`: state enum (IDLE, FILL) and field-width/offset helper functions, given LINES and LINE_WORDS.
- Sub-module `icache_data_array`: data storage with combinational read port (index, offset) and one write port (index, offset, data, we).
- Tag and valid arrays plus the FSM stay in `icache`.

## Test plan
- Cold miss:
  - Stimulus: after reset, `cache_rd` = 1, `cache_addr` = 0x100; memory returns 0x100+i at word i.
  - Response: `mem_addr` issues 0x100, 0x104, 0x108, 0x10C; waitrequest drops in cycle 6 with `cache_data` = 0x100.
- Same-line hit: a following read of 0x10C returns 0x10C with waitrequest 0 in the same cycle; no `mem_rd`.
- Conflict miss:
  - Stimulus: read 0x100 (LINES=64, line 16 bytes), then 0x500, which maps to the same index.
  - Response: refill of 0x500; a later read of 0x100 misses again.
- Memory backpressure:
  - Stimulus: `mem_waitrequest` high for 3 cycles on the second request, with variable `mem_rvalid` gaps.
  - Response: `mem_addr` is held at 0x104; all 4 words land correctly.
- Flush during FILL:
  - Stimulus: `flush` pulse on the cycle after the miss.
  - Response: the fill completes, then a re-read of the same address misses again. A flush in IDLE after a fill also forces a miss.
- Reset mid-FILL:
  - Stimulus: assert `reset_n` low after 2 responses.
  - Response: `mem_rd` = 0 and the FSM is in IDLE. A later read misses and refills from word 0. With `ICACHE_STATS_EN`, the counters read 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Everything above the index and the word offset, minus the 2 byte-select bits.
  function automatic int tag_bits(input int addr_width, input int lines, input int line_words);
    return addr_width - 2 - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side read port and memory-side pipelined refill port of the instruction cache.
interface icache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_rd;
  logic [DATA_WIDTH-1:0] cache_data;
  logic                  cache_waitrequest;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_waitrequest;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rvalid;

  modport slave (
    input  cache_addr, cache_rd, flush, mem_waitrequest, mem_data, mem_rvalid,
    output cache_data, cache_waitrequest, mem_addr, mem_rd
  );

  modport master (
    output cache_addr, cache_rd, flush, mem_waitrequest, mem_data, mem_rvalid,
    input  cache_data, cache_waitrequest, mem_addr, mem_rd
  );
endinterface

// File: rtl/icache_data_array.sv
// Instruction word storage: flop array, combinational read, single write port.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clock,
  input  logic [idx_bits(LINES)-1:0]      rd_idx,
  input  logic [off_bits(LINE_WORDS)-1:0] rd_off,
  output logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            we,
  input  logic [idx_bits(LINES)-1:0]      wr_idx,
  input  logic [off_bits(LINE_WORDS)-1:0] wr_off,
  input  logic [DATA_WIDTH-1:0]           wr_data
);
  logic [LINES-1:0][LINE_WORDS-1:0][DATA_WIDTH-1:0] mem;

  assign rd_data = mem[rd_idx][rd_off];

  always_ff @(posedge clock)
    if (we) mem[wr_idx][wr_off] <= wr_data;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with full-line refill over a pipelined read port.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OB     = off_bits(LINE_WORDS);
  localparam int IB     = idx_bits(LINES);
  localparam int TB     = tag_bits(ADDR_WIDTH, LINES, LINE_WORDS);
  localparam int LAST_I = LINE_WORDS - 1;
  localparam logic [OB:0]   WORDS = LINE_WORDS[OB:0];
  localparam logic [OB-1:0] LAST  = LAST_I[OB-1:0];

  state_t                 state, state_nxt;
  logic [LINES-1:0]       valid;
  logic [LINES-1:0][TB-1:0] tags;
  logic [TB-1:0]          fill_tag;
  logic [IB-1:0]          fill_idx;
  logic [OB:0]            req_cnt;
  logic [OB-1:0]          resp_cnt;
  logic                   kill;

  logic [OB-1:0]          offset;
  logic [IB-1:0]          idx;
  logic [TB-1:0]          tag;
  logic                   hit, start, busy, refill_rd, last_rsp, fill_we;
  logic [ADDR_WIDTH-1:0]  refill_addr;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   unused_byte_sel;

  assign offset          = bus.cache_addr[OB+1:2];
  assign idx             = bus.cache_addr[OB+2 +: IB];
  assign tag             = bus.cache_addr[ADDR_WIDTH-1 -: TB];
  assign unused_byte_sel = ^bus.cache_addr[1:0];

  assign hit      = bus.cache_rd & valid[idx] & (tags[idx] == tag) & ~bus.flush;
  assign fill_we  = (state == FILL) & bus.mem_rvalid;
  assign last_rsp = fill_we & (resp_cnt == LAST);

  icache_data_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINES     (LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_data (
    .clock  (clock),
    .rd_idx (idx),
    .rd_off (offset),
    .rd_data(rd_data),
    .we     (fill_we),
    .wr_idx (fill_idx),
    .wr_off (resp_cnt),
    .wr_data(bus.mem_data)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    refill_rd   = 1'b0;
    refill_addr = '0;
    start       = 1'b0;
    case (state)
      IDLE: begin
        busy = bus.cache_rd & ~hit;
        if (bus.cache_rd && !hit && !bus.flush) begin
          start     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy        = 1'b1;
        refill_rd   = (req_cnt < WORDS);
        refill_addr = {fill_tag, fill_idx, req_cnt[OB-1:0], 2'b00};
        if (last_rsp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cache_data        = rd_data;
  assign bus.cache_waitrequest = busy;
  assign bus.mem_rd            = refill_rd;
  assign bus.mem_addr          = refill_addr;

  // A flush that lands during a refill poisons the line so it completes invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      req_cnt  <= '0;
      resp_cnt <= '0;
      kill     <= 1'b0;
    end else begin
      if (bus.flush) valid <= '0;
      if (start) begin
        fill_tag <= tag;
        fill_idx <= idx;
        req_cnt  <= '0;
        resp_cnt <= '0;
        kill     <= 1'b0;
      end
      if (state == FILL) begin
        if (refill_rd && !bus.mem_waitrequest) req_cnt <= req_cnt + 1'b1;
        if (bus.flush) kill <= 1'b1;
        if (bus.mem_rvalid) resp_cnt <= resp_cnt + 1'b1;
        if (last_rsp) valid[fill_idx] <= ~(kill | bus.flush);
      end
    end
  end

  always_ff @(posedge clock)
    if (last_rsp) tags[fill_idx] <= fill_tag;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && hit) hit_count <= hit_count + 1'b1;
      if (start) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: vector table of fetches plus hand sequences for refill corner cases.
module tb_icache;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
    int          reqs;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  icache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LINES     (64),
    .LINE_WORDS(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: word data equals its address, responses one cycle after acceptance.
  logic [31:0] pend[$];
  logic [31:0] log_q[$];
  logic [31:0] cyc = 0;
  int          rsp_n = 0;
  int          bp_cnt = 0;
  int          bp_seen = 0;
  logic        bp_en = 1'b0;
  logic [7:0]  gap_pat = 8'b0110_1001;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.mem_rvalid === 1'b1 && pend.size() > 0) begin
      void'(pend.pop_front());
      rsp_n <= rsp_n + 1;
    end
    if (bus.mem_rd === 1'b1 && bus.mem_waitrequest === 1'b0) begin
      pend.push_back(bus.mem_addr);
      log_q.push_back(bus.mem_addr);
    end
    if (!bp_en) bp_cnt <= 0;
    else if (bus.mem_rd === 1'b1 && bus.mem_waitrequest === 1'b1) bp_cnt <= bp_cnt + 1;
  end

  always @(negedge clock) begin
    bus.mem_rvalid      <= (pend.size() > 0) && !(bp_en && gap_pat[cyc[2:0]]);
    bus.mem_data        <= (pend.size() > 0) ? pend[0] : 32'h0;
    bus.mem_waitrequest <= bp_en && (bus.mem_rd === 1'b1) && (bus.mem_addr[3:2] == 2'd1) && (bp_cnt < 3);
  end

  always @(negedge clock) begin
    #1;
    if (bp_en && bus.mem_rd === 1'b1 && bus.mem_waitrequest === 1'b1) begin
      bp_seen <= bp_seen + 1;
      check("bp_addr_held", bus.mem_addr, 32'h104);
    end
  end

  // Holds cache_rd until the cache stops waiting; entered and left at posedge+1.
  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int waits, output int first);
    first = log_q.size();
    waits = 0;
    d = 'x;
    bus.cache_addr = a;
    bus.cache_rd = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (bus.cache_waitrequest === 1'b0) begin
        d = bus.cache_data;
        break;
      end
      waits++;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    bus.cache_rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] d;
    int          w, f, r0;

    vecs[0]  = '{32'h0000_0100, 32'h0000_0100, 6, 4};
    vecs[1]  = '{32'h0000_010C, 32'h0000_010C, 0, 0};
    vecs[2]  = '{32'h0000_0104, 32'h0000_0104, 0, 0};
    vecs[3]  = '{32'h0000_0103, 32'h0000_0100, 0, 0};
    vecs[4]  = '{32'h0000_0500, 32'h0000_0500, 6, 4};
    vecs[5]  = '{32'h0000_050C, 32'h0000_050C, 0, 0};
    vecs[6]  = '{32'h0000_0100, 32'h0000_0100, 6, 4};
    vecs[7]  = '{32'h0000_0208, 32'h0000_0208, 6, 4};
    vecs[8]  = '{32'h0000_0108, 32'h0000_0108, 0, 0};
    vecs[9]  = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 6, 4};
    vecs[10] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 0};
    vecs[11] = '{32'h0000_0500, 32'h0000_0500, 6, 4};

    bus.cache_addr = 32'h100;
    bus.cache_rd   = 1'b1;
    bus.flush      = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_waitrequest", {31'b0, bus.cache_waitrequest}, 32'd1);
    check("reset_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.cache_rd = 1'b0;
    @(negedge clock);
    check("idle_no_rd_wait", {31'b0, bus.cache_waitrequest}, 32'd0);
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) begin
      fetch(vecs[i].addr, d, w, f);
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_waits", i), 32'(w), 32'(vecs[i].waits));
      check($sformatf("vec%0d_reqs", i), 32'(log_q.size() - f), 32'(vecs[i].reqs));
      if (vecs[i].reqs == 4 && log_q.size() - f == 4)
        for (int k = 0; k < 4; k++)
          check($sformatf("vec%0d_mem_addr%0d", i, k), log_q[f+k], (vecs[i].addr & 32'hFFFF_FFF0) + 32'(4*k));
    end
`ifdef ICACHE_STATS_EN
    check("stat_hits", hit_count, 32'd12);
    check("stat_misses", miss_count, 32'd6);
`endif

    // Flush in IDLE, then a refill of 0x100 against a stalling, gappy memory.
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    bp_en = 1'b1;
    fetch(32'h100, d, w, f);
    bp_en = 1'b0;
    check("bp_data", d, 32'h100);
    check("bp_reqs", 32'(log_q.size() - f), 32'd4);
    check("bp_stall_cycles", 32'(bp_seen), 32'd3);
    for (int k = 1; k < 4; k++) begin
      fetch(32'h100 + 32'(4*k), d, w, f);
      check($sformatf("bp_word%0d_data", k), d, 32'h100 + 32'(4*k));
      check($sformatf("bp_word%0d_waits", k), 32'(w), 32'd0);
    end

    // Flush the cycle after a miss: the killed line forces a second refill.
    fork
      fetch(32'h600, d, w, f);
      begin
        @(posedge clock); #1;
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
      end
    join
    check("flush_fill_data", d, 32'h600);
    check("flush_fill_waits", 32'(w), 32'd12);
    check("flush_fill_reqs", 32'(log_q.size() - f), 32'd8);
    fetch(32'h60C, d, w, f);
    check("after_flush_hit_data", d, 32'h60C);
    check("after_flush_hit_waits", 32'(w), 32'd0);

    // Reset after two responses of a refill.
    bus.cache_addr = 32'h900;
    bus.cache_rd = 1'b1;
    r0 = rsp_n;
    for (int c = 0; c < 40 && (rsp_n - r0) < 2; c++) begin
      @(posedge clock); #1;
    end
    check("rst_resp_seen", 32'(rsp_n - r0), 32'd2);
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_waitrequest", {31'b0, bus.cache_waitrequest}, 32'd1);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.cache_rd = 1'b0;
    for (int c = 0; c < 40 && pend.size() > 0; c++) begin
      @(posedge clock); #1;
    end
    check("rst_drain", 32'(pend.size()), 32'd0);
    repeat (2) begin
      @(posedge clock); #1;
    end
    fetch(32'h900, d, w, f);
    check("post_rst_data", d, 32'h900);
    check("post_rst_waits", 32'(w), 32'd6);
    check("post_rst_first_addr", (log_q.size() > f) ? log_q[f] : 32'hDEAD_BEEF, 32'h900);
    fetch(32'h60C, d, w, f);
    check("post_rst_old_line_miss", 32'(w), 32'd6);
    check("post_rst_old_line_data", d, 32'h60C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
